// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive-side buffering blocks.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   // Index width needed to address a storage array of the given depth.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra MSB so full and empty
// can be told apart when the low bits match. The caller must not push when full
// (unless popping) nor pop when empty.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [ptr_w(DEPTH):0]    o_count
);

   localparam int PW = ptr_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW:0]      r_wr_ptr;
   logic [PW:0]      r_rd_ptr;

   // Pointer update; wrap-around falls out of the natural binary rollover.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= {(PW+1){1'b0}};
         r_rd_ptr <= {(PW+1){1'b0}};
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
      end
   end

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_rdata = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: one capture per frame from the recv_valid level, FIFO,
// sticky overflow. Build macro UART_RX_BUFFER_BREAK_EN diverts break frames to break_det.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    recv_valid,
   input  logic [UART_DATA_W-1:0]  recv_data,
   input  logic                    recv_break,
   output logic [UART_DATA_W-1:0]  rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [CW-1:0]           count,
   output logic                    overflow,
   input  logic                    clear_overflow,
   output logic                    break_det
);

   logic                    r_v1;
   logic                    r_v2;
   logic                    r_overflow;
   logic                    w_strobe;
   logic                    w_is_break;
   logic                    w_push_req;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_drop;
   logic                    w_full;
   logic                    w_empty;
   logic [UART_DATA_W-1:0]  w_wdata;
   logic [UART_DATA_W-1:0]  w_rdata;
   logic [ptr_w(DEPTH):0]   w_count;

   // Valid history resets high so a frame already underway at reset release is skipped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_v1 <= 1'b1;
         r_v2 <= 1'b1;
      end else begin
         r_v1 <= recv_valid;
         r_v2 <= r_v1;
      end
   end

   assign w_strobe = recv_valid & r_v1 & ~r_v2;

`ifdef UART_RX_BUFFER_BREAK_EN
   logic r_break_det;

   assign w_is_break = recv_break;

   // One-cycle break pulse, in place of storing the break byte.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_break_det <= 1'b0;
      end else begin
         r_break_det <= w_strobe & recv_break;
      end
   end

   assign break_det = r_break_det;
`else
   assign w_is_break = 1'b0;
   assign break_det  = 1'b0;
`endif

   assign w_wdata    = recv_break ? 8'h00 : recv_data;
   assign w_push_req = w_strobe & ~w_is_break;
   assign w_pop      = rd_ready & ~w_empty;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   // A drop in the same cycle as a clear wins so no lost byte goes unreported.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clear_overflow) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign rd_data  = w_rdata;
   assign rd_valid = ~w_empty;
   assign count    = CW'(w_count);
   assign overflow = r_overflow;

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; power of two, >= 2.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, width of count output.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port recv_valid  input  1  receiver byte-available level; high for whole stop-bit period.
REQ-006 SHALL have port recv_data  input  8  received byte; updates on the first recv_valid cycle, valid from the second.
REQ-007 SHALL have port recv_break  input  1  break indication, qualified the same way as recv_data.
REQ-008 SHALL have port rd_data  output  8  head-of-FIFO byte (show-ahead).
REQ-009 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts head byte.
REQ-011 SHALL have port count  output  CW  bytes currently stored, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: a byte was dropped because FIFO was full.
REQ-013 SHALL have port clear_overflow  input  1  synchronous clear of overflow.
REQ-014 SHALL have port break_det  output  1  one-cycle pulse on a received break.

Function
REQ-015 SHALL register recv_valid twice (v1, v2); capture strobe = recv_valid & v1 & ~v2, i.e. exactly once per frame, on the second cycle of recv_valid.
REQ-016 SHALL write recv_data into the FIFO on a strobe cycle if not full; byte visible on rd_data/rd_valid the following cycle.
REQ-017 SHALL pop the head byte when rd_valid & rd_ready; rd_data shows the next byte the following cycle.
REQ-018 SHALL, when full and strobe without pop, drop the byte, leave FIFO unchanged and set overflow the next cycle.
REQ-019 SHALL, when full with simultaneous strobe and pop, accept the write; count stays DEPTH; overflow unchanged.
REQ-020 SHALL, when empty with strobe and rd_ready, ignore rd_ready (no pop of empty); write proceeds.
REQ-021 SHALL update count by +1 on write only, -1 on pop only, 0 on both or neither.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full/empty from an extra pointer MSB.
REQ-023 SHALL drive rd_data = 8'h00 whenever rd_valid is low.
REQ-024 SHALL clear overflow on clear_overflow; a simultaneous new drop takes priority (overflow stays 1).
REQ-025 SHALL ignore rd_ready whose assertion changes nothing when rd_valid low; no other handshake constraint.

Reset
REQ-026 SHALL on resetn low asynchronously set pointers 0, count 0, rd_valid 0, rd_data 8'h00, overflow 0, break_det 0.
REQ-027 SHALL reset v1 and v2 to 1 so a frame in progress across reset release is not captured.
REQ-028 SHALL not reset storage array contents.

Configuration
REQ-029 SHALL use macro UART_RX_BUFFER_BREAK_EN.
REQ-030 SHALL, with macro defined, on strobe with recv_break high: not write the byte, pulse break_det for one cycle.
REQ-031 SHALL, without macro, store break bytes as 8'h00 like any data and tie break_det to 0.

Structure
REQ-032 SHALL take UART byte width constant (8) and pointer-width helper from shared package uart_pkg.
REQ-033 SHALL place storage and pointers in sub-module uart_sync_fifo (DEPTH, WIDTH params, push/pop/full/empty/count); edge detect, overflow and break logic stay in uart_rx_buffer.

Verification
REQ-034 SHALL cover: recv_valid high 16 cycles, recv_data 8'hA5 from cycle 2, rd_ready 0 -> one write, rd_valid=1, rd_data=8'hA5, count=1.
REQ-035 SHALL cover: 17 frames (8'h00..8'h10) with rd_ready 0, DEPTH 16 -> count=16, overflow=1, 8'h10 dropped, reads return 8'h00..8'h0F.
REQ-036 SHALL cover: FIFO full, strobe of 8'h55 with rd_ready=1 same cycle -> count stays 16, overflow 0, 8'h55 read last.
REQ-037 SHALL cover: recv_valid held high across resetn release -> no write, count=0.
REQ-038 SHALL cover: frame 8'h00 with recv_break=1 -> macro defined: break_det one pulse, count 0; undefined: count 1, rd_data 8'h00, break_det 0.
REQ-039 SHALL cover: overflow=1, clear_overflow pulse with no drop -> overflow 0 next cycle; with concurrent drop -> stays 1.
